// File: rtl/jtframe_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sdram_pkg
// Description : Shared encodings for the cheat-subsystem SDRAM bank-0 arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package jtframe_sdram_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_GAME = 2'd1;
    localparam logic [STATE_W-1:0] ST_AUX  = 2'd2;

    localparam logic OWN_GAME = 1'b0;
    localparam logic OWN_AUX  = 1'b1;

    // Index width for a channel count, never narrower than one bit
    function automatic int idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_cheat_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_cheat_arb_if
// Description : Game, auxiliary and SDRAM bank-0 signals of the cheat arbiter
// Revision    : 1.0 - initial release
// ============================================================================
interface jtframe_cheat_arb_if #(
    parameter int AW = 22,
    parameter int DW = 16,
    parameter int CH = 2
);
    logic              lock;
    logic [AW-1:0]     game_addr;
    logic              game_rd;
    logic              game_wr;
    logic [DW-1:0]     game_din;
    logic [1:0]        game_din_m;
    logic              game_ack;
    logic              game_dst;
    logic              game_rdy;
    logic [CH-1:0]     aux_req;
    logic [CH-1:0]     aux_we;
    logic [CH*AW-1:0]  aux_addr;
    logic [CH*DW-1:0]  aux_din;
    logic [CH*2-1:0]   aux_din_m;
    logic [CH-1:0]     aux_busy;
    logic [CH-1:0]     aux_done;
    logic [CH-1:0]     aux_err;
    logic [CH*DW-1:0]  aux_dout;
    logic [AW-1:0]     ba0_addr;
    logic              ba0_rd;
    logic              ba0_wr;
    logic [DW-1:0]     ba0_din;
    logic [1:0]        ba0_din_m;
    logic              ba0_ack;
    logic              ba0_dst;
    logic              ba0_rdy;
    logic [DW-1:0]     data_read;
    logic              timeout;

    // Arbiter side
    modport slave (
        input  lock, game_addr, game_rd, game_wr, game_din, game_din_m,
        input  aux_req, aux_we, aux_addr, aux_din, aux_din_m,
        input  ba0_ack, ba0_dst, ba0_rdy, data_read,
        output game_ack, game_dst, game_rdy,
        output aux_busy, aux_done, aux_err, aux_dout,
        output ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m, timeout
    );

    // Environment side (game core, aux masters, SDRAM controller)
    modport master (
        output lock, game_addr, game_rd, game_wr, game_din, game_din_m,
        output aux_req, aux_we, aux_addr, aux_din, aux_din_m,
        output ba0_ack, ba0_dst, ba0_rdy, data_read,
        input  game_ack, game_dst, game_rdy,
        input  aux_busy, aux_done, aux_err, aux_dout,
        input  ba0_addr, ba0_rd, ba0_wr, ba0_din, ba0_din_m, timeout
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_rr_pick
// Description : Combinational round-robin pick: first pending at/after ptr
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_rr_pick #(
    parameter int CH = 2,
    parameter int IW = 1
) (
    input  wire logic [CH-1:0] pend,
    input  wire logic [IW-1:0] ptr,
    output logic      [CH-1:0] oh,
    output logic      [IW-1:0] idx,
    output logic               vld
);
    logic          hi_v;
    logic [IW-1:0] hi_i;
    logic [IW-1:0] lo_i;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        hi_v = 1'b0;
        hi_i = '0;
        lo_i = '0;
        vld  = 1'b0;
        for (int j = CH - 1; j >= 0; j--) begin
            if (pend[j]) begin
                vld  = 1'b1;
                lo_i = IW'(j);
                if (IW'(j) >= ptr) begin
                    hi_v = 1'b1;
                    hi_i = IW'(j);
                end
            end
        end
        idx = hi_v ? hi_i : lo_i;
        oh  = '0;
        for (int j = 0; j < CH; j++) begin
            oh[j] = vld && (IW'(j) == idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_cheat_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_cheat_arb
// Description : SDRAM bank-0 arbiter: game pass-through plus round-robin aux
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_cheat_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int AW  = 22,
    parameter int DW  = 16,
    parameter int CH  = 2,
    parameter int TOW = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    jtframe_cheat_arb_if.slave bus
);
    localparam int IW = idx_w(CH);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CH-1:0]      busy_q, busy_d;
    logic [CH-1:0]      done_q, done_d;
    logic [CH-1:0]      err_q, err_d;
    logic [CH-1:0]      we_q, we_d;
    logic [AW-1:0]      addr_q [CH];
    logic [AW-1:0]      addr_d [CH];
    logic [DW-1:0]      din_q [CH];
    logic [DW-1:0]      din_d [CH];
    logic [1:0]         din_m_q [CH];
    logic [1:0]         din_m_d [CH];
    logic [DW-1:0]      dout_q [CH];
    logic [DW-1:0]      dout_d [CH];
    logic [IW-1:0]      sel_q, sel_d;
    logic [CH-1:0]      sel_oh_q, sel_oh_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [TOW-1:0]     cnt_q, cnt_d;
    logic               acked_q, acked_d;
    logic               timeout_q, timeout_d;

    logic [CH-1:0]      w_pick_oh;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic               w_game_req;
    logic               w_expire;
    logic               w_owner;

    assign w_game_req = bus.game_rd | bus.game_wr;
    assign w_expire   = (cnt_q == {TOW{1'b1}}) && !bus.ba0_rdy;

    jtframe_rr_pick #(.CH(CH), .IW(IW)) u_pick (
        .pend (busy_q),
        .ptr  (rr_q),
        .oh   (w_pick_oh),
        .idx  (w_pick_idx),
        .vld  (w_pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Game always wins against pending aux work when both show up in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_game_req)      state_d = ST_GAME;
                else if (w_pick_vld) state_d = ST_AUX;
            end
            ST_GAME, ST_AUX: begin
                if (bus.ba0_rdy || w_expire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_owner = (state_q == ST_AUX) ? OWN_AUX : OWN_GAME;
        if (w_owner == OWN_GAME) begin
            bus.ba0_addr  = bus.game_addr;
            bus.ba0_rd    = bus.game_rd;
            bus.ba0_wr    = bus.game_wr;
            bus.ba0_din   = bus.game_din;
            bus.ba0_din_m = bus.game_din_m;
        end else begin
            bus.ba0_addr  = addr_q[sel_q];
            bus.ba0_rd    = !acked_q && !we_q[sel_q];
            bus.ba0_wr    = !acked_q &&  we_q[sel_q];
            bus.ba0_din   = din_q[sel_q];
            bus.ba0_din_m = din_m_q[sel_q];
        end
        bus.game_ack = (w_owner == OWN_GAME) && bus.ba0_ack;
        bus.game_dst = (w_owner == OWN_GAME) && bus.ba0_dst;
        bus.game_rdy = (w_owner == OWN_GAME) && bus.ba0_rdy;
        bus.aux_busy = busy_q;
        bus.aux_done = done_q;
        bus.aux_err  = err_q;
        bus.timeout  = timeout_q;
    end

    for (genvar i = 0; i < CH; i++) begin : g_pack
        assign bus.aux_dout[i*DW +: DW] = dout_q[i];
    end

    always_comb begin
        busy_d    = busy_q;
        done_d    = '0;
        err_d     = err_q;
        we_d      = we_q;
        addr_d    = addr_q;
        din_d     = din_q;
        din_m_d   = din_m_q;
        dout_d    = dout_q;
        sel_d     = sel_q;
        sel_oh_d  = sel_oh_q;
        rr_d      = rr_q;
        acked_d   = acked_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q + 1'b1;

        if (state_q == ST_IDLE) begin
            cnt_d   = '0;
            acked_d = 1'b0;
            if (!w_game_req && w_pick_vld) begin
                sel_d    = w_pick_idx;
                sel_oh_d = w_pick_oh;
            end
        end

        if (state_q == ST_AUX) begin
            if (bus.ba0_ack) acked_d = 1'b1;
            if (bus.ba0_dst && !we_q[sel_q]) dout_d[sel_q] = bus.data_read;
            if (bus.ba0_rdy) begin
                done_d = sel_oh_q;
                busy_d = busy_q & ~sel_oh_q;
                rr_d   = (sel_q == IW'(CH - 1)) ? '0 : sel_q + 1'b1;
            end else if (w_expire) begin
                busy_d    = busy_q & ~sel_oh_q;
                err_d     = err_q | sel_oh_q;
                timeout_d = 1'b1;
            end
        end else if (state_q == ST_GAME && w_expire) begin
            timeout_d = 1'b1;
        end

        // Only idle channels accept; a channel finishing this cycle is already idle
        for (int i = 0; i < CH; i++) begin
            if (bus.aux_req[i] && !busy_q[i] && !bus.lock) begin
                busy_d[i]  = 1'b1;
                err_d[i]   = 1'b0;
                we_d[i]    = bus.aux_we[i];
                addr_d[i]  = bus.aux_addr[i*AW +: AW];
                din_d[i]   = bus.aux_din[i*DW +: DW];
                din_m_d[i] = bus.aux_din_m[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            we_q      <= '0;
            addr_q    <= '{default: '0};
            din_q     <= '{default: '0};
            din_m_q   <= '{default: '0};
            dout_q    <= '{default: '0};
            sel_q     <= '0;
            sel_oh_q  <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            acked_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            din_m_q   <= din_m_d;
            dout_q    <= dout_d;
            sel_q     <= sel_d;
            sel_oh_q  <= sel_oh_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            acked_q   <= acked_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_cheat_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_cheat_arb
// Description : Directed self-checking bench for jtframe_cheat_arb
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_cheat_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n;

    always #5 clk = ~clk;

    jtframe_cheat_arb_if #(.AW(22), .DW(16), .CH(2)) bus ();

    jtframe_cheat_arb #(.AW(22), .DW(16), .CH(2), .TOW(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one aux transfer starting in its first AUX cycle; ends in the cycle after ba0_rdy
    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [15:0] rdata);
        chk({tag, "_addr"}, 32'(bus.ba0_addr), 32'(exp_addr));
        chk({tag, "_strobe_on"}, 32'(bus.ba0_rd | bus.ba0_wr), 32'd1);
        bus.ba0_ack = 1'b1;
        tick();
        bus.ba0_ack = 1'b0;
        chk({tag, "_strobe_off"}, 32'(bus.ba0_rd | bus.ba0_wr), 32'd0);
        bus.ba0_dst   = 1'b1;
        bus.data_read = rdata;
        tick();
        bus.ba0_dst = 1'b0;
        bus.ba0_rdy = 1'b1;
        #1;
        chk({tag, "_game_rdy_gated"}, 32'(bus.game_rdy), 32'd0);
        tick();
        bus.ba0_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        bus.lock       = 1'b0;
        bus.game_addr  = '0;
        bus.game_rd    = 1'b0;
        bus.game_wr    = 1'b0;
        bus.game_din   = '0;
        bus.game_din_m = '0;
        bus.aux_req    = '0;
        bus.aux_we     = '0;
        bus.aux_addr   = '0;
        bus.aux_din    = '0;
        bus.aux_din_m  = '0;
        bus.ba0_ack    = 1'b0;
        bus.ba0_dst    = 1'b0;
        bus.ba0_rdy    = 1'b0;
        bus.data_read  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.aux_busy), 32'd0);
        chk("rst_done", 32'(bus.aux_done), 32'd0);
        chk("rst_err", 32'(bus.aux_err), 32'd0);
        chk("rst_dout", bus.aux_dout, 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        rst_n = 1'b1;
        tick();

        // Game read passes straight through
        bus.game_addr = 22'h1234;
        bus.game_rd   = 1'b1;
        #1;
        chk("game_rd_pass", 32'(bus.ba0_rd), 32'd1);
        chk("game_addr_pass", 32'(bus.ba0_addr), 32'h1234);
        tick();
        bus.ba0_ack = 1'b1;
        #1;
        chk("game_ack", 32'(bus.game_ack), 32'd1);
        tick();
        bus.ba0_ack = 1'b0;
        bus.ba0_rdy = 1'b1;
        bus.game_rd = 1'b0;
        #1;
        chk("game_rdy", 32'(bus.game_rdy), 32'd1);
        chk("game_aux_idle", 32'(bus.aux_busy), 32'd0);
        tick();
        bus.ba0_rdy = 1'b0;

        // Single ch0 read
        bus.aux_addr = {22'h0, 22'h000100};
        bus.aux_we   = 2'b00;
        bus.aux_req  = 2'b01;
        tick();
        bus.aux_req = 2'b00;
        chk("c0_busy", 32'(bus.aux_busy), 32'b01);
        chk("c0_no_grant_yet", 32'(bus.ba0_rd), 32'd0);
        tick();
        serve("c0", 22'h000100, 16'hBEEF);
        chk("c0_done", 32'(bus.aux_done), 32'b01);
        chk("c0_busy_clr", 32'(bus.aux_busy), 32'b00);
        chk("c0_dout", 32'(bus.aux_dout[15:0]), 32'hBEEF);
        tick();
        chk("c0_done_pulse", 32'(bus.aux_done), 32'b00);

        // Pair with pointer at 1 after ch0: ch1 then ch0
        bus.aux_addr = {22'h000200, 22'h000300};
        bus.aux_req  = 2'b11;
        tick();
        bus.aux_req = 2'b00;
        chk("p_busy", 32'(bus.aux_busy), 32'b11);
        tick();
        serve("p1", 22'h000200, 16'h1111);
        chk("p1_done", 32'(bus.aux_done), 32'b10);
        chk("p1_busy", 32'(bus.aux_busy), 32'b01);
        chk("p1_dout", 32'(bus.aux_dout[31:16]), 32'h1111);
        chk("p_idle_gap", 32'(bus.ba0_rd), 32'd0);
        tick();
        serve("p2", 22'h000300, 16'h2222);
        chk("p2_done", 32'(bus.aux_done), 32'b01);
        chk("p2_dout", 32'(bus.aux_dout), 32'h1111_2222);
        tick();

        // Game coincident with pending ch1
        bus.aux_addr = {22'h000400, 22'h0};
        bus.aux_req  = 2'b10;
        tick();
        bus.aux_req   = 2'b00;
        bus.game_addr = 22'h005555;
        bus.game_rd   = 1'b1;
        #1;
        chk("g1_game_wins", 32'(bus.ba0_addr), 32'h5555);
        tick();
        chk("g1_game_state", 32'(bus.ba0_addr), 32'h5555);
        chk("g1_ch1_wait", 32'(bus.aux_busy), 32'b10);
        bus.ba0_rdy = 1'b1;
        bus.game_rd = 1'b0;
        #1;
        chk("g1_game_rdy", 32'(bus.game_rdy), 32'd1);
        tick();
        bus.ba0_rdy = 1'b0;
        chk("g1_idle", 32'(bus.ba0_rd), 32'd0);
        tick();
        serve("g1", 22'h000400, 16'h3333);
        chk("g1_done", 32'(bus.aux_done), 32'b10);
        tick();

        // Write issued before lock completes; request under lock is dropped
        bus.aux_addr  = {22'h000500, 22'h000600};
        bus.aux_din   = {16'h0, 16'hA5A5};
        bus.aux_din_m = 4'b0001;
        bus.aux_we    = 2'b01;
        bus.aux_req   = 2'b01;
        tick();
        bus.lock    = 1'b1;
        bus.aux_req = 2'b10;
        tick();
        bus.aux_req = 2'b00;
        chk("lk_busy", 32'(bus.aux_busy), 32'b01);
        chk("lk_wr", 32'(bus.ba0_wr), 32'd1);
        chk("lk_din", 32'(bus.ba0_din), 32'hA5A5);
        chk("lk_din_m", 32'(bus.ba0_din_m), 32'b01);
        serve("lk", 22'h000600, 16'hDEAD);
        chk("lk_done", 32'(bus.aux_done), 32'b01);
        chk("lk_dout_kept", 32'(bus.aux_dout[15:0]), 32'h2222);
        tick();
        tick();
        chk("lk_quiet", 32'({bus.ba0_rd, bus.ba0_wr, bus.aux_busy}), 32'd0);
        bus.lock = 1'b0;

        // Timeout on an unanswered write
        bus.aux_addr = {22'h0, 22'h000700};
        bus.aux_req  = 2'b01;
        tick();
        bus.aux_req = 2'b00;
        tick();
        chk("to_wr", 32'(bus.ba0_wr), 32'd1);
        bus.ba0_ack = 1'b1;
        tick();
        bus.ba0_ack = 1'b0;
        n = 1;
        while (!bus.timeout && n < 400) begin
            tick();
            n++;
        end
        chk("to_latency", 32'(n), 32'd256);
        chk("to_err", 32'(bus.aux_err), 32'b01);
        chk("to_busy", 32'(bus.aux_busy), 32'b00);
        chk("to_no_done", 32'(bus.aux_done), 32'b00);
        tick();
        chk("to_pulse", 32'(bus.timeout), 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_err", 32'(bus.aux_err), 32'd0);
        chk("rst2_dout", bus.aux_dout, 32'd0);
        chk("rst2_busy", 32'(bus.aux_busy), 32'd0);

        // Pointer back at 0: ch0 first, and ch0 re-request on its done cycle
        bus.aux_we   = 2'b00;
        bus.aux_addr = {22'h000020, 22'h000010};
        bus.aux_req  = 2'b11;
        tick();
        bus.aux_req = 2'b00;
        tick();
        serve("r0", 22'h000010, 16'h4444);
        chk("r0_done", 32'(bus.aux_done), 32'b01);
        bus.aux_addr = {22'h000020, 22'h000030};
        bus.aux_req  = 2'b01;
        tick();
        bus.aux_req = 2'b00;
        chk("r0_rereq", 32'(bus.aux_busy), 32'b11);
        serve("r1", 22'h000020, 16'h5555);
        chk("r1_done", 32'(bus.aux_done), 32'b10);
        tick();
        serve("r2", 22'h000030, 16'h6666);
        chk("r2_done", 32'(bus.aux_done), 32'b01);
        chk("r2_dout", 32'(bus.aux_dout), 32'h5555_6666);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
